// File: rtl/cp0_regfile.sv
// CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC and ErrorEPC.
// Handles MTC0/MFC0, the Count/Compare timer, interrupt sampling, exception entry and ERET.
module cp0_regfile #(
    parameter int N_HWINT    = 6,
    parameter int COUNT_DIV  = 2,
    parameter int TIMER_LINE = 5
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [4:0]         raddr,
    output logic [31:0]        rdata,
    input  logic               we,
    input  logic [4:0]         waddr,
    input  logic [31:0]        wdata,
    input  logic               exc_valid,
    input  logic [4:0]         exc_code,
    input  logic [31:0]        exc_pc,
    input  logic               exc_bd,
    input  logic               exc_badv_we,
    input  logic [31:0]        exc_badvaddr,
    input  logic               eret,
    input  logic [N_HWINT-1:0] hw_int,
    output logic               int_req,
    output logic [31:0]        status_o,
    output logic [31:0]        cause_o,
    output logic [31:0]        epc_o
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_ERROREPC = 5'd30;

    localparam logic [31:0] STATUS_RST = 32'h0040_0000;
    localparam logic [31:0] STATUS_M   = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_M    = 32'h0000_0300;

    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [31:0]      badvaddr_q, badvaddr_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      compare_q, compare_d;
    logic [31:0]      status_q, status_d;
    logic [31:0]      cause_q, cause_d;
    logic [31:0]      epc_q, epc_d;
    logic [31:0]      errorepc_q, errorepc_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             int_req_q, int_req_d;

    logic             wr;
    logic             tick;
    logic [5:0]       hw_ext;

    always_comb begin
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        compare_d  = compare_q;
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        errorepc_d = errorepc_q;
        div_d      = div_q;
        hw_ext     = '0;

        // An exception in the same cycle swallows any MTC0.
        wr   = we & ~exc_valid;
        tick = (div_q == DIV_LAST);

        if (wr) begin
            case (waddr)
                REG_COMPARE:  compare_d  = wdata;
                REG_STATUS:   status_d   = (status_q & ~STATUS_M) | (wdata & STATUS_M);
                REG_CAUSE:    cause_d    = (cause_q & ~CAUSE_M) | (wdata & CAUSE_M);
                REG_EPC:      epc_d      = wdata;
                REG_ERROREPC: errorepc_d = wdata;
                default:      ;
            endcase
        end

        if (wr && waddr == REG_COUNT) begin
            count_d = wdata;
            div_d   = '0;
        end else begin
            div_d   = tick ? '0 : div_q + DIV_W'(1);
            count_d = count_q + {31'b0, tick};
        end

        // Compare write clears TI and beats a coincident match.
        if (wr && waddr == REG_COMPARE) begin
            cause_d[30] = 1'b0;
        end else if (count_d == compare_q) begin
            cause_d[30] = 1'b1;
        end

        hw_ext[N_HWINT-1:0]       = hw_int;
        cause_d[15:10]            = hw_ext;
        cause_d[10 + TIMER_LINE]  = hw_ext[TIMER_LINE] | cause_d[30];

        if (exc_valid) begin
            cause_d[6:2] = exc_code;
            if (!status_q[1]) begin
                epc_d       = exc_bd ? exc_pc - 32'd4 : exc_pc;
                cause_d[31] = exc_bd;
            end
            status_d[1] = 1'b1;
            if (exc_badv_we) begin
                badvaddr_d = exc_badvaddr;
            end
        end else if (eret) begin
            status_d[1] = 1'b0;
        end

        // Built from registered state so the request lags the causing edge by one cycle.
        int_req_d = status_q[0] & ~status_q[1] & (|(cause_q[15:8] & status_q[15:8]));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            status_q   <= STATUS_RST;
            cause_q    <= '0;
            epc_q      <= '0;
            errorepc_q <= '0;
            div_q      <= '0;
            int_req_q  <= 1'b0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            errorepc_q <= errorepc_d;
            div_q      <= div_d;
            int_req_q  <= int_req_d;
        end
    end

    always_comb begin
        case (raddr)
            REG_BADVADDR: rdata = badvaddr_q;
            REG_COUNT:    rdata = count_q;
            REG_COMPARE:  rdata = compare_q;
            REG_STATUS:   rdata = status_q;
            REG_CAUSE:    rdata = cause_q;
            REG_EPC:      rdata = epc_q;
            REG_ERROREPC: rdata = errorepc_q;
            default:      rdata = 32'h0;
        endcase
    end

    assign int_req  = int_req_q;
    assign status_o = status_q;
    assign cause_o  = cause_q;
    assign epc_o    = epc_q;

endmodule
